// File: rtl/fp_sum_feeder_if.sv
// fp_sum_feeder bus bundle: scalar input stream, sum-module control and result stream.
// The feeder takes the slave side; the environment takes the master side.
interface fp_sum_feeder_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      s_data;
    logic             s_valid;
    logic             s_last;
    logic             s_ready;
    logic [511:0]     op_vec;
    logic             sum_clock_en;
    logic             sum_acc_sign;
    logic [31:0]      result_all;
    logic [31:0]      m_data;
    logic [CNT_W-1:0] m_count;
    logic             m_valid;
    logic             m_ready;

    modport slave (
        input  s_data, s_valid, s_last, result_all, m_ready,
        output s_ready, op_vec, sum_clock_en, sum_acc_sign,
        output m_data, m_count, m_valid
    );

    modport master (
        output s_data, s_valid, s_last, result_all, m_ready,
        input  s_ready, op_vec, sum_clock_en, sum_acc_sign,
        input  m_data, m_count, m_valid
    );
endinterface

// File: rtl/fp_sum_feeder.sv
// fp_sum_feeder: packs a scalar FP32 stream into 16-lane vectors for the
// adder tree, drains its pipeline and returns the reduced sum and count.
module fp_sum_feeder #(
    parameter logic [3:0] LATENCY = 4'd5,
    parameter int         CNT_W   = 16
) (
    input  logic               aclk,
    input  logic               aresetn,
    fp_sum_feeder_if.slave     bus
);

    typedef enum logic [1:0] {
        FILL,
        ISSUE,
        DRAIN,
        OUT
    } state_t;

    state_t            r_state;
    logic [15:0][31:0] r_lane;
    logic [3:0]        r_idx;
    logic [CNT_W-1:0]  r_cnt;
    logic [3:0]        r_drain;
    logic              r_first;
    logic              r_has_last;
    logic              r_clk_en;
    logic              r_acc_sign;
    logic              r_m_valid;
    logic [31:0]       r_m_data;
    logic [CNT_W-1:0]  r_m_count;

    logic              w_s_ready;
    logic              w_accept;
    logic [CNT_W-1:0]  w_cnt_inc;

    assign w_s_ready = (r_state == FILL) & aresetn;
    assign w_accept  = w_s_ready & bus.s_valid;
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

    assign bus.s_ready      = w_s_ready;
    assign bus.op_vec       = (r_state == ISSUE) ? r_lane : '0;
    assign bus.sum_clock_en = r_clk_en;
    assign bus.sum_acc_sign = r_acc_sign;
    assign bus.m_valid      = r_m_valid;
    assign bus.m_data       = r_m_data;
    assign bus.m_count      = r_m_count;

    // Sequencer: fill lanes, issue one vector, drain the tree, hold the result.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state    <= FILL;
            r_lane     <= '0;
            r_idx      <= 4'd0;
            r_cnt      <= '0;
            r_drain    <= 4'd0;
            r_first    <= 1'b1;
            r_has_last <= 1'b0;
            r_clk_en   <= 1'b0;
            r_acc_sign <= 1'b0;
            r_m_valid  <= 1'b0;
            r_m_data   <= 32'd0;
            r_m_count  <= '0;
        end else begin
            unique case (r_state)
                FILL: begin
                    if (w_accept) begin
                        r_lane[r_idx] <= bus.s_data;
                        r_idx         <= r_idx + 4'd1;
                        r_cnt         <= w_cnt_inc;
                        if (r_idx == 4'd15 || bus.s_last) begin
                            r_state    <= ISSUE;
                            r_clk_en   <= 1'b1;
                            r_acc_sign <= ~r_first;
                            r_has_last <= bus.s_last;
                        end
                    end
                end
                ISSUE: begin
                    r_lane  <= '0;
                    r_idx   <= 4'd0;
                    r_first <= 1'b0;
                    if (r_has_last) begin
                        r_state    <= DRAIN;
                        r_drain    <= 4'd0;
                        r_acc_sign <= 1'b1;
                    end else begin
                        r_state    <= FILL;
                        r_clk_en   <= 1'b0;
                        r_acc_sign <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (r_drain == LATENCY - 4'd1) begin
                        r_m_data   <= bus.result_all;
                        r_m_count  <= r_cnt;
                        r_m_valid  <= 1'b1;
                        r_clk_en   <= 1'b0;
                        r_acc_sign <= 1'b0;
                        r_state    <= OUT;
                    end else begin
                        r_drain <= r_drain + 4'd1;
                    end
                end
                OUT: begin
                    if (bus.m_ready) begin
                        r_m_valid <= 1'b0;
                        r_cnt     <= '0;
                        r_first   <= 1'b1;
                        r_state   <= FILL;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

endmodule
